// File: rtl/mxu_pkg.sv
// Shared types and defaults for the MXU pass sequencer.
package mxu_pkg;

   localparam int MXU_ARRAY_DIM = 4;
   localparam int MXU_MAX_M     = 256;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      FIN    = 3'd4
   } mxu_seq_state_e;

   // Psums need one hop per row plus one per column to leave the array.
   function automatic int drain_cycles(input int n);
      return 2 * n;
   endfunction

endpackage

// File: rtl/mxu_sequencer_if.sv
// Command and array/SRAM control bundle between host, sequencer and the PE array.
interface mxu_sequencer_if
   import mxu_pkg::*;
#(
   parameter int ARRAY_DIM = MXU_ARRAY_DIM,
   parameter int MAX_M     = MXU_MAX_M
);
   localparam int WT_AW  = $clog2(ARRAY_DIM);
   localparam int ACT_AW = $clog2(MAX_M);
   localparam int MW     = $clog2(MAX_M + 1);

   logic                 start;
   logic [MW-1:0]        m_rows;
   logic                 busy;
   logic                 done;
   logic                 wt_rd_en;
   logic [WT_AW-1:0]     wt_rd_addr;
   logic [ARRAY_DIM-1:0] pe_load_en;
   logic                 act_rd_en;
   logic [ACT_AW-1:0]    act_rd_addr;
   logic                 pe_compute;
   logic [ARRAY_DIM-1:0] col_valid;

   modport master (
      output start, m_rows,
      input  busy, done, wt_rd_en, wt_rd_addr, pe_load_en,
             act_rd_en, act_rd_addr, pe_compute, col_valid
   );

   modport slave (
      input  start, m_rows,
      output busy, done, wt_rd_en, wt_rd_addr, pe_load_en,
             act_rd_en, act_rd_addr, pe_compute, col_valid
   );

endinterface

// File: rtl/valid_delay_line.sv
// Shift register tracking activation reads through SRAM, skew and array hops;
// exposes the top NTAPS stages as per-column result valids.
module valid_delay_line
   import mxu_pkg::*;
#(
   parameter int DEPTH = 2 * MXU_ARRAY_DIM,
   parameter int NTAPS = MXU_ARRAY_DIM
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vld_i,
   output logic [NTAPS-1:0] taps_o
);

   logic [DEPTH-1:0] sr_q;

   always_ff @(posedge clk) begin
      if (rst) sr_q <= '0;
      else     sr_q <= {sr_q[DEPTH-2:0], vld_i};
   end

   // sr_q[k] is vld_i delayed by k+1 cycles.
   assign taps_o = sr_q[DEPTH-1 -: NTAPS];

endmodule

// File: rtl/mxu_sequencer.sv
// One weight-stationary matmul pass: load N weight rows, stream M activation
// vectors, drain the array, then pulse done.
module mxu_sequencer
   import mxu_pkg::*;
#(
   parameter int ARRAY_DIM = MXU_ARRAY_DIM,
   parameter int MAX_M     = MXU_MAX_M
) (
   input  logic           clk,
   input  logic           rst,
   mxu_sequencer_if.slave bus
);

   localparam int WT_AW     = $clog2(ARRAY_DIM);
   localparam int ACT_AW    = $clog2(MAX_M);
   localparam int MW        = $clog2(MAX_M + 1);
   localparam int LCW       = $clog2(ARRAY_DIM + 1);
   localparam int VCW       = ACT_AW + 1;
   localparam int DRAIN_LEN = drain_cycles(ARRAY_DIM);
   localparam int DCW       = $clog2(DRAIN_LEN);

   function automatic logic [VCW-1:0] clamp_m(input logic [MW-1:0] m);
      if (32'(m) > 32'(MAX_M)) return VCW'(MAX_M);
      return VCW'(m);
   endfunction

   mxu_seq_state_e       state_q, state_d;
   logic [LCW-1:0]       ld_cnt_q, ld_cnt_d;
   logic [VCW-1:0]       vec_cnt_q, vec_cnt_d;
   logic [VCW-1:0]       m_q, m_d;
   logic [DCW-1:0]       dr_cnt_q, dr_cnt_d;
   logic [ARRAY_DIM-1:0] load_q, load_d;

   logic busy, done, wt_rd_en, act_rd_en, pe_compute;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ld_cnt_q  <= '0;
         vec_cnt_q <= '0;
         m_q       <= '0;
         dr_cnt_q  <= '0;
         load_q    <= '0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         vec_cnt_q <= vec_cnt_d;
         m_q       <= m_d;
         dr_cnt_q  <= dr_cnt_d;
         load_q    <= load_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ld_cnt_d   = ld_cnt_q;
      vec_cnt_d  = vec_cnt_q;
      m_d        = m_q;
      dr_cnt_d   = dr_cnt_q;
      load_d     = '0;
      busy       = 1'b0;
      done       = 1'b0;
      wt_rd_en   = 1'b0;
      act_rd_en  = 1'b0;
      pe_compute = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               m_d      = clamp_m(bus.m_rows);
               ld_cnt_d = '0;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            busy = 1'b1;
            // Extra final cycle lets the last row's one-hot land with its SRAM data.
            if (ld_cnt_q < LCW'(ARRAY_DIM)) begin
               wt_rd_en = 1'b1;
               load_d   = ARRAY_DIM'(1) << ld_cnt_q;
               ld_cnt_d = ld_cnt_q + LCW'(1);
            end else begin
               vec_cnt_d = '0;
               dr_cnt_d  = '0;
               state_d   = (m_q == '0) ? FIN : STREAM;
            end
         end
         STREAM: begin
            busy       = 1'b1;
            act_rd_en  = 1'b1;
            pe_compute = 1'b1;
            vec_cnt_d  = vec_cnt_q + VCW'(1);
            if (vec_cnt_q == m_q - VCW'(1)) begin
               dr_cnt_d = '0;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            busy       = 1'b1;
            pe_compute = 1'b1;
            dr_cnt_d   = dr_cnt_q + DCW'(1);
            if (dr_cnt_q == DCW'(DRAIN_LEN - 1)) state_d = FIN;
         end
         FIN: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.wt_rd_en    = wt_rd_en;
   assign bus.wt_rd_addr  = wt_rd_en ? ld_cnt_q[WT_AW-1:0] : '0;
   assign bus.pe_load_en  = load_q;
   assign bus.act_rd_en   = act_rd_en;
   assign bus.act_rd_addr = act_rd_en ? vec_cnt_q[ACT_AW-1:0] : '0;
   assign bus.pe_compute  = pe_compute;

   valid_delay_line #(
      .DEPTH (DRAIN_LEN),
      .NTAPS (ARRAY_DIM)
   ) u_vdl (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (act_rd_en),
      .taps_o (bus.col_valid)
   );

endmodule
